nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around a 4-bit carry-lookahead slice.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake and adds one nibble per cycle, least-significant nibble first.
- The carry between nibbles is held in a register, so one 4-bit CLA slice serves any width.
- Sits between the operand source and the result consumer wherever a wide add is needed without a wide combinational carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair and cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  sum/cout/ovf are valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow (carry into MSB XOR cout)
- busy  output  1  high while in ADD state

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Both are fixed.
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, ovf 0, busy 0, in_ready 1, nibble index 0, carry register 0.
- FSM has three states: IDLE, ADD, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). busy = (state == ADD).
- IDLE:
  - On in_valid && in_ready, capture a, b into operand shift registers, carry register <= cin, index <= 0, go to ADD.
  - Otherwise stay in IDLE.
- ADD, each cycle:
  - Slice inputs are low nibbles of the A/B shift registers plus the carry register.
  - Slice computes g = a&b, p = a^b, c0 = carry, c(i+1) = g(i) | p(i)&c(i), s = p^c.
  - Sum register shifts right by 4 with the slice sum inserted at the top nibble. Operand registers shift right by 4.
  - Carry register <= slice carry-out. index <= index + 1.
  - When index == NIBBLES-1: register cout <= slice carry-out and ovf <= slice c3 XOR slice carry-out, then go to DONE.
- DONE:
  - sum, cout, ovf held stable.
  - On out_ready, go to IDLE. Output registers keep their values; only out_valid drops.
- Latency: operands accepted at edge k give out_valid high after edge k+NIBBLES. WIDTH=4 gives 1 cycle.
- Throughput: no overlap between operations. Minimum NIBBLES+2 cycles per add with out_ready held high: DONE->IDLE takes 1 edge, accept takes 1 edge.
- in_valid is ignored whenever in_ready is 0. Changes on a/b/cin after acceptance have no effect.
- out_ready is ignored outside DONE.
- Reset mid-operation, in ADD or DONE: the operation is aborted with no output. Next cycle all reset values apply and in_ready = 1.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is meaningful for signed interpretation only.

Test Plan:
1. WIDTH=16: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; busy high for those 4 cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Carry must propagate across all four nibble boundaries.
3. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. a=0x0000, b=0xFFFF, cin=1 -> sum=0x0000, cout=1. Then WIDTH=4 instance: a=6, b=10, cin=0 -> sum=0, cout=1 after 1 cycle; a=15, b=9 -> sum=8, cout=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands. Required: sum/cout stable, in_ready=0, new operands not captured. Raise out_ready -> IDLE next edge, then new operands accepted.
6. Assert rst for one cycle during the 2nd ADD cycle -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1. A following add of 0x00FF+0x0001 yields 0x0100, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Wide adder that adds one nibble per clock through a single 4-bit carry-lookahead slice.
// The slice's carry-out is held in a register and fed into the next, more significant nibble.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic               carry_reg, carry_next;
   logic               cout_reg, cout_next;
   logic               ovf_reg, ovf_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;

   // 4-bit carry-lookahead slice on the low nibble of the operand shift registers
   logic [3:0] slice_g;
   logic [3:0] slice_p;
   logic [3:0] slice_s;
   logic [4:0] slice_c;

   assign slice_g    = a_reg[3:0] & b_reg[3:0];
   assign slice_p    = a_reg[3:0] ^ b_reg[3:0];
   assign slice_c[0] = carry_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_carry
         assign slice_c[gi+1] = slice_g[gi] | (slice_p[gi] & slice_c[gi]);
      end
   endgenerate

   assign slice_s = slice_p ^ slice_c[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
         ovf_reg   <= ovf_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sum_next   = sum_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      ovf_next   = ovf_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               carry_next = cin;
               idx_next   = '0;
               state_next = ADD;
            end
         end
         ADD: begin
            a_next     = a_reg >> 4;
            b_next     = b_reg >> 4;
            // After NIBBLES shifts the first nibble computed lands in bits [3:0]
            sum_next   = sum_reg >> 4;
            sum_next[WIDTH-1 -: 4] = slice_s;
            carry_next = slice_c[4];
            idx_next   = idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
               cout_next  = slice_c[4];
               ovf_next   = slice_c[3] ^ slice_c[4];
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == ADD);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit and a 4-bit instance share clock and reset.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
   logic        cout16, ovf16, busy16;
   logic [15:0] a16, b16, sum16;

   logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
   logic        cout4, ovf4, busy4;
   logic [3:0]  a4, b4, sum4;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one 16-bit add through the handshake and checks latency, busy and the result.
   task automatic run_add16(input string name, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic [15:0] exp_sum, input logic exp_cout,
                            input logic exp_ovf);
      int cycles;
      logic busy_ok;
      a16 = av; b16 = bv; cin16 = cv; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = 1'b1;
      cycles = 0;
      busy_ok = 1'b1;
      while (!out_valid16 && cycles < 20) begin
         if (busy16 !== 1'b1 || in_ready16 !== 1'b0) busy_ok = 1'b0;
         tick();
         cycles++;
      end
      checks++;
      if (cycles !== 4) $display("FAIL %s latency: got %0d cycles, expected 4", name, cycles);
      else passed++;
      checks++;
      if (busy_ok !== 1'b1) $display("FAIL %s busy: busy/in_ready wrong during ADD", name);
      else passed++;
      checks++;
      if ({sum16, cout16, ovf16} !== {exp_sum, exp_cout, exp_ovf})
         $display("FAIL %s result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                  name, sum16, cout16, ovf16, exp_sum, exp_cout, exp_ovf);
      else passed++;
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      checks++;
      if ({in_ready16, out_valid16, sum16} !== {1'b1, 1'b0, exp_sum})
         $display("FAIL %s release: got in_ready=%b out_valid=%b sum=%h, expected 1 0 %h",
                  name, in_ready16, out_valid16, sum16, exp_sum);
      else passed++;
   endtask

   task automatic run_add4(input string name, input logic [3:0] av, input logic [3:0] bv,
                           input logic cv, input logic [3:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
      a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      checks++;
      if (busy4 !== 1'b1) $display("FAIL %s busy: got %b, expected 1", name, busy4);
      else passed++;
      tick();
      checks++;
      if ({out_valid4, sum4, cout4, ovf4} !== {1'b1, exp_sum, exp_cout, exp_ovf})
         $display("FAIL %s result: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                  name, out_valid4, sum4, cout4, ovf4, exp_sum, exp_cout, exp_ovf);
      else passed++;
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      checks++;
      if (in_ready4 !== 1'b1) $display("FAIL %s release: got in_ready=%b, expected 1", name, in_ready4);
      else passed++;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready16, out_valid16, busy16, sum16, cout16, ovf16} !== {3'b100, 16'h0, 2'b00})
         $display("FAIL reset16: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, expected 1 0 0 0000 0 0",
                  in_ready16, out_valid16, busy16, sum16, cout16, ovf16);
      else passed++;
      checks++;
      if ({in_ready4, out_valid4, busy4, sum4, cout4, ovf4} !== {3'b100, 4'h0, 2'b00})
         $display("FAIL reset4: got rdy=%b vld=%b busy=%b sum=%h, expected 1 0 0 0",
                  in_ready4, out_valid4, busy4, sum4);
      else passed++;
   endtask

   task automatic test_basic();
      run_add16("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
   endtask

   task automatic test_carry_chain();
      run_add16("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      run_add16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_add16("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
   endtask

   task automatic test_cin();
      run_add16("cin", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_width4();
      run_add4("w4_a", 4'd6, 4'd10, 1'b0, 4'd0, 1'b1, 1'b0);
      run_add4("w4_b", 4'd15, 4'd9, 1'b0, 4'd8, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int cycles;
      logic hold_ok;
      a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; in_valid16 = 1'b1;
      tick();
      a16 = 16'hAAAA; b16 = 16'h5555;
      for (int i = 0; i < 4; i++) tick();
      hold_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if ({out_valid16, in_ready16, sum16, cout16} !== {1'b1, 1'b0, 16'h3333, 1'b0}) hold_ok = 1'b0;
         tick();
      end
      checks++;
      if (hold_ok !== 1'b1) $display("FAIL backpressure hold: outputs not stable or operands captured");
      else passed++;
      checks++;
      if ({out_valid16, sum16} !== {1'b1, 16'h3333})
         $display("FAIL backpressure final: got vld=%b sum=%h, expected 1 3333", out_valid16, sum16);
      else passed++;
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
      checks++;
      if ({in_ready16, out_valid16} !== 2'b10)
         $display("FAIL backpressure idle: got in_ready=%b out_valid=%b, expected 1 0", in_ready16, out_valid16);
      else passed++;
      tick();
      in_valid16 = 1'b0;
      checks++;
      if (busy16 !== 1'b1) $display("FAIL backpressure accept: got busy=%b, expected 1", busy16);
      else passed++;
      cycles = 0;
      while (!out_valid16 && cycles < 20) begin
         tick();
         cycles++;
      end
      checks++;
      if ({cycles == 4, sum16, cout16, ovf16} !== {1'b1, 16'hFFFF, 2'b00})
         $display("FAIL backpressure second: got cycles=%0d sum=%h cout=%b ovf=%b, expected 4 ffff 0 0",
                  cycles, sum16, cout16, ovf16);
      else passed++;
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic quiet;
      a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({in_ready16, out_valid16, busy16, sum16, cout16} !== {3'b100, 16'h0, 1'b0})
         $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b sum=%h cout=%b, expected 1 0 0 0000 0",
                  in_ready16, out_valid16, busy16, sum16, cout16);
      else passed++;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid16 !== 1'b0) quiet = 1'b0;
         tick();
      end
      checks++;
      if (quiet !== 1'b1) $display("FAIL reset_mid quiet: out_valid rose after abort");
      else passed++;
      run_add16("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b0;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_basic();
      test_carry_chain();
      test_overflow();
      test_cin();
      test_width4();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
